uart_dev: RTL

Memory-mapped 8N1 UART peripheral occupying the UART device slot behind the CPU–device bridge (byte addresses 0x7F10–0x7F2B, seven word registers). It serialises bytes written by the CPU onto `uart_txd` and deserialises frames arriving on `uart_rxd` into a holding register. It raises a level interrupt that the bridge routes to `HWInt[1]`. Register reads are combinational; every state change happens on the `CLK` rising edge.

---
 rtl/uart_dev.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 UART with combinational register reads,
// a programmable baud divisor and a level interrupt for the bridge.
module uart_dev #(
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Register-file state
    logic [1:0]  r_ier;
    logic [15:0] r_div;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_frame_err;

    // Transmitter state
    tx_state_t   r_tx_state,  w_tx_state_n;
    logic [15:0] r_tx_cnt,    w_tx_cnt_n;
    logic [2:0]  r_tx_bit,    w_tx_bit_n;
    logic [7:0]  r_tx_shift,  w_tx_shift_n;
    logic [15:0] r_tx_div,    w_tx_div_n;
    logic        r_txd,       w_txd_n;

    // Receiver state
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    rx_state_t   r_rx_state,  w_rx_state_n;
    logic [15:0] r_rx_cnt,    w_rx_cnt_n;
    logic [2:0]  r_rx_bit,    w_rx_bit_n;
    logic [7:0]  r_rx_shift,  w_rx_shift_n;
    logic [15:0] r_rx_div,    w_rx_div_n;
    logic        w_rx_done;

    // Decoded write strobes and derived status
    logic        w_wr_data;
    logic        w_wr_ier;
    logic        w_wr_lsr;
    logic        w_wr_div;
    logic [15:0] w_div_clamped;
    logic        w_tx_ready;
    logic        w_rx_pend;
    logic        w_tx_pend;

    assign w_wr_data     = WE && (Addr == 3'd0);
    assign w_wr_ier      = WE && (Addr == 3'd1);
    assign w_wr_lsr      = WE && (Addr == 3'd5);
    assign w_wr_div      = WE && (Addr == 3'd6);
    assign w_div_clamped = (WD[15:0] < 16'd2) ? 16'd2 : WD[15:0];

    assign w_tx_ready = (r_tx_state == TX_IDLE);
    assign w_rx_pend  = r_rx_valid & r_ier[0];
    assign w_tx_pend  = w_tx_ready & r_ier[1];
    assign IRQ        = w_rx_pend | w_tx_pend;
    assign uart_txd   = r_txd;

    // Combinational register read mux
    always_comb begin
        RD = '0;
        case (Addr)
            3'd0:    RD = {24'b0, r_rx_data};
            3'd1:    RD = {30'b0, r_ier};
            3'd2:    RD = {30'b0, w_tx_pend, w_rx_pend};
            3'd5:    RD = {26'b0, w_tx_ready, 2'b0, r_frame_err, r_overrun, r_rx_valid};
            3'd6:    RD = {16'b0, r_div};
            default: RD = '0;
        endcase
    end

    // Control registers: interrupt enables and baud divisor
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ier <= '0;
            r_div <= DEFAULT_DIV;
        end else begin
            if (w_wr_ier) r_ier <= WD[1:0];
            if (w_wr_div) r_div <= w_div_clamped;
        end
    end

    // TX state register; line idles high and is forced high by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_div   <= DEFAULT_DIV;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_div   <= w_tx_div_n;
            r_txd      <= w_txd_n;
        end
    end

    // TX next-state: each state holds for div cycles, counter runs div-1 down to 0
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_div_n   = r_tx_div;
        w_txd_n      = r_txd;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd_n = 1'b1;
                if (w_wr_data) begin
                    w_tx_state_n = TX_START;
                    w_txd_n      = 1'b0;
                    w_tx_shift_n = WD[7:0];
                    w_tx_div_n   = r_div;
                    w_tx_cnt_n   = r_div - 16'd1;
                end
            end
            TX_START: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_state_n = TX_DATA;
                    w_txd_n      = r_tx_shift[0];
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_n   = 3'd0;
                    w_tx_cnt_n   = r_tx_div - 16'd1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else if (r_tx_bit == 3'd7) begin
                    w_tx_state_n = TX_STOP;
                    w_txd_n      = 1'b1;
                    w_tx_cnt_n   = r_tx_div - 16'd1;
                end else begin
                    w_txd_n      = r_tx_shift[0];
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_n   = r_tx_bit + 3'd1;
                    w_tx_cnt_n   = r_tx_div - 16'd1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_state_n = TX_IDLE;
                    w_txd_n      = 1'b1;
                end
            end
            default: begin
                w_tx_state_n = TX_IDLE;
                w_txd_n      = 1'b1;
            end
        endcase
    end

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_div   <= DEFAULT_DIV;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_div   <= w_rx_div_n;
        end
    end

    // RX next-state: half-bit to the start centre, then full bits to each centre
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_div_n   = r_rx_div;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_s2 && r_rx_prev) begin
                    w_rx_state_n = RX_START;
                    w_rx_div_n   = r_div;
                    w_rx_cnt_n   = {1'b0, r_div[15:1]} - 16'd1;
                end
            end
            RX_START: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end else if (r_rx_s2) begin
                    w_rx_state_n = RX_IDLE;
                end else begin
                    w_rx_state_n = RX_DATA;
                    w_rx_bit_n   = 3'd0;
                    w_rx_cnt_n   = r_rx_div - 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_n   = r_rx_div - 16'd1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_done    = 1'b1;
                    w_rx_state_n = RX_IDLE;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // RX holding register and line status; a same-cycle LSR clear lets the new byte in
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr_lsr) begin
                r_rx_valid  <= 1'b0;
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_rx_done) begin
                if (r_rx_valid && !w_wr_lsr) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data   <= r_rx_shift;
                    r_rx_valid  <= 1'b1;
                    r_frame_err <= ~r_rx_s2;
                end
            end
        end
    end

endmodule
